mul4_fitness_scorer: RTL and testbench
======================================

// Module: mul4_fitness_scorer
// PURPOSE
//  Downstream scoring stage for evolved 2x2-bit multiplier candidates in the mul4 vector tournament.
//  Each bit position ("lane") of the 16-bit vectors is one test case:
//   - operands: a={a1,a0}, b={b1,b0}
//   - candidate answer: y={y3,y2,y1,y0}
//  Per lane, the block compares the candidate answer with the golden 4-bit product and counts correct
//  output bits. It accumulates that count over BATCHES beats and reports one fitness score per evaluation.
// PARAMETERS
//  LANES    16   test cases per beat (vector width)
//  BATCHES  4    beats per evaluation
//  SCORE_W  $clog2(4*LANES*BATCHES+1)   score width (9 with defaults)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        pulse: begin new evaluation (honoured only in IDLE)
//  in_valid   in   1        beat valid
//  in_ready   out  1        beat accepted when in_valid&in_ready
//  a1,a0      in   LANES    operand A bits per lane
//  b1,b0      in   LANES    operand B bits per lane
//  y3..y0     in   LANES    candidate output bits per lane
//  out_valid  out  1        score available
//  out_ready  in   1        consumer takes score
//  score      out  SCORE_W  correct output bits over the evaluation
//  perfect    out  1        score == 4*LANES*BATCHES; valid with out_valid
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE.
//    Reset values: in_ready=0, out_valid=0, score=0, perfect=0, busy=0, accumulator=0, beat count=0,
//    pipeline valids=0.
//  - Golden product per lane i:
//      p0=a0&b0
//      p1=(a1&b0)^(a0&b1)
//      p2=a1&b1&~(a0&b0)
//      p3=a1&a0&b1&b0
//  - FSM states:
//    - IDLE: start=1 clears accumulator and beat count -> ACCUM.
//    - ACCUM: in_ready=1. Each accepted beat increments beat count.
//      On acceptance of beat BATCHES-1 -> FLUSH, and in_ready drops the next cycle.
//    - FLUSH: in_ready=0. Waits until both pipeline stages are empty -> REPORT.
//    - REPORT: out_valid=1 and score/perfect are held stable until out_ready=1 -> IDLE.
//      out_valid deasserts on the next cycle.
//  - Pipeline: 2 stages, fully pipelined (one beat per cycle).
//    - S1 registers match = ~({y3,y2,y1,y0} ^ {p3,p2,p1,p0}), 4*LANES bits.
//    - S2 adds popcount(match) (0..4*LANES) to the accumulator.
//    - Latency from last accepted beat to out_valid: 3 cycles.
//  - Width: the accumulator is SCORE_W bits and cannot overflow, because the maximum is 4*LANES*BATCHES.
//  - Boundaries:
//    - start outside IDLE is ignored.
//    - in_valid outside ACCUM is ignored (not accepted).
//    - start and out_ready together in REPORT: the handshake completes -> IDLE; start is not honoured
//      that cycle.
//    - Gaps in in_valid during ACCUM are allowed. The beat count advances only on handshakes.
//    - rst_n low mid-evaluation aborts immediately; the partial score is discarded and no out_valid is
//      produced.
// STRUCTURE
//  - Package mul4_eval_pkg:
//    - state_t enum {IDLE,ACCUM,FLUSH,REPORT}
//    - function golden_prod(a1,a0,b1,b0) returning 4 bits
//    - localparam BITS_PER_LANE=4
//  - Sub-module mul4_lane_popcount: combinational popcount of the 4*LANES match vector, output
//    $clog2(4*LANES+1) bits. Instantiated once in S2.
// TESTING
//  Lane encoding: lane i carries a=i[3:2], b=i[1:0] (all 16 operand pairs).
//  - Correct answers: 4 beats of exhaustive lanes, y=golden -> score=256, perfect=1,
//    out_valid 3 cycles after beat 4.
//  - All-zero answers: 4 exhaustive beats, y=0 -> 14 golden one-bits per beat, so score=4*(64-14)=200,
//    perfect=0.
//  - Backpressure: hold out_ready=0 for 10 cycles in REPORT -> score stable and out_valid=1 throughout;
//    in_ready=0; start ignored.
//  - Bubbles: in_valid toggling 1,0,0,1,... with correct answers -> score=256, and exactly 4 beats are
//    accepted.
//  - Mid-op reset: assert rst_n=0 after 2 beats, then start a fresh run with y=0 -> all outputs return to
//    reset values immediately; the fresh run scores 200, with no leftover from the aborted run.
//  - Single wrong bit: correct beats except lane 15 y3 flipped in beat 2 -> score=255, perfect=0.

Source files
------------

// File: rtl/mul4_eval_pkg.sv
// Shared types and the golden 2x2-bit product used by the mul4 fitness scorer.
package mul4_eval_pkg;

    localparam int BITS_PER_LANE = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FLUSH  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Returns {p3,p2,p1,p0} of a*b for 2-bit operands a={a1,a0}, b={b1,b0}.
    function automatic logic [3:0] golden_prod(input logic a1, input logic a0,
                                               input logic b1, input logic b0);
        golden_prod = {a1 & a0 & b1 & b0,
                       a1 & b1 & ~(a0 & b0),
                       (a1 & b0) ^ (a0 & b1),
                       a0 & b0};
    endfunction

endpackage

// File: rtl/mul4_lane_popcount.sv
// Combinational popcount of the per-lane match vector.
module mul4_lane_popcount #(
    parameter int N     = 64,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     bits_in,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CNT_W'(bits_in[i]);
        end
    end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Scores evolved 2x2 multiplier candidates: counts correct output bits across BATCHES beats.
//
// state  | meaning
// IDLE   | waiting for start; accumulator cleared when start is taken
// ACCUM  | accepting beats until BATCHES handshakes have occurred
// FLUSH  | no new beats; draining S1/S2 into the accumulator
// REPORT | score presented until the consumer takes it
module mul4_fitness_scorer
    import mul4_eval_pkg::*;
#(
    parameter int LANES   = 16,
    parameter int BATCHES = 4,
    parameter int SCORE_W = $clog2(4 * LANES * BATCHES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES-1:0]   a1,
    input  logic [LANES-1:0]   a0,
    input  logic [LANES-1:0]   b1,
    input  logic [LANES-1:0]   b0,
    input  logic [LANES-1:0]   y3,
    input  logic [LANES-1:0]   y2,
    input  logic [LANES-1:0]   y1,
    input  logic [LANES-1:0]   y0,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] score,
    output logic               perfect,
    output logic               busy
);

    localparam int MATCH_W   = BITS_PER_LANE * LANES;
    localparam int CNT_W     = $clog2(MATCH_W + 1);
    localparam int BEAT_W    = $clog2(BATCHES + 1);
    localparam int MAX_SCORE = MATCH_W * BATCHES;

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [SCORE_W-1:0]   acc_q, acc_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [MATCH_W-1:0]   s1_match_q, s1_match_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [MATCH_W-1:0]   match;
    logic [CNT_W-1:0]     pop_count;
    logic                 accept;

    assign accept = in_valid && (state_q == ACCUM);

    always_comb begin
        match = '0;
        for (int i = 0; i < LANES; i++) begin
            match[BITS_PER_LANE*i +: BITS_PER_LANE] =
                ~({y3[i], y2[i], y1[i], y0[i]} ^ golden_prod(a1[i], a0[i], b1[i], b0[i]));
        end
    end

    mul4_lane_popcount #(.N(MATCH_W), .CNT_W(CNT_W)) u_popcount (
        .bits_in (s1_match_q),
        .count   (pop_count)
    );

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        acc_d      = acc_q;
        s1_valid_d = accept;
        s1_match_d = accept ? match : s1_match_q;
        s2_valid_d = s1_valid_q;

        if (s1_valid_q) begin
            acc_d = acc_q + SCORE_W'(pop_count);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d      = '0;
                    beat_cnt_d = '0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_cnt_q == BEAT_W'(BATCHES - 1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                // start in the same cycle as out_ready is deliberately dropped
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_match_q <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
            s1_valid_q <= s1_valid_d;
            s1_match_q <= s1_match_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == REPORT);
    assign busy      = (state_q != IDLE);
    assign score     = acc_q;
    assign perfect   = out_valid && (acc_q == SCORE_W'(MAX_SCORE));

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Scoreboard bench for mul4_fitness_scorer: expected scores queued at stimulus time, checked at out_valid.
module tb_mul4_fitness_scorer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a1 = '0, a0 = '0, b1 = '0, b0 = '0;
    logic [15:0] y3 = '0, y2 = '0, y1 = '0, y0 = '0;
    logic        in_ready, out_valid, perfect, busy;
    logic [8:0]  score;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    mul4_fitness_scorer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a1        (a1),
        .a0        (a0),
        .b1        (b1),
        .b0        (b0),
        .y3        (y3),
        .y2        (y2),
        .y1        (y1),
        .y0        (y0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .score     (score),
        .perfect   (perfect),
        .busy      (busy)
    );

    // Lane i: a=i[3:2], b=i[1:0]; golden product from integer multiply.
    task automatic build_beat(input bit correct, input bit flip15, output int beat_score);
        beat_score = 0;
        for (int i = 0; i < 16; i++) begin
            logic [1:0] av;
            logic [1:0] bv;
            logic [3:0] p;
            logic [3:0] y;
            av = 2'(i / 4);
            bv = 2'(i % 4);
            p  = 4'(int'(av) * int'(bv));
            y  = correct ? p : 4'b0000;
            if (flip15 && i == 15) y[3] = ~y[3];
            a1[i] = av[1]; a0[i] = av[0];
            b1[i] = bv[1]; b0[i] = bv[0];
            y3[i] = y[3]; y2[i] = y[2]; y1[i] = y[1]; y0[i] = y[0];
            for (int j = 0; j < 4; j++) if (y[j] == p[j]) beat_score++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_taken: busy=%b in_ready=%b expected 1/1", busy, in_ready);
        end
    endtask

    task automatic drive_eval(input bit correct, input int flip_beat, input bit bubble, input int n_beats);
        int beats = 0;
        int k = 0;
        int bs;
        int exp_sum = 0;
        while (beats < n_beats && k < 100) begin
            build_beat(correct, beats == flip_beat, bs);
            in_valid = bubble ? (k % 3 == 0) : 1'b1;
            if (in_valid && in_ready) begin
                beats++;
                exp_sum += bs;
            end
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (beats != n_beats) begin
            n_fail++;
            $display("FAIL beats_accepted: got %0d expected %0d", beats, n_beats);
        end
        if (n_beats == 4) exp_q.push_back(exp_sum);
    endtask

    task automatic check_latency(input bit hold_valid);
        in_valid = hold_valid;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_ready_drop: got %b expected 0", in_ready);
        end
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== (c == 3)) begin
                n_fail++;
                $display("FAIL latency_c%0d: out_valid=%b expected %b", c, out_valid, (c == 3));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        int guard = 0;
        int e;
        while (out_valid !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: out_valid=%b expected 1", tag, out_valid);
            return;
        end
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_unexpected: score %0d with empty scoreboard", tag, score);
            return;
        end
        e = exp_q.pop_front();
        n_tests++;
        if (score !== 9'(e)) begin
            n_fail++;
            $display("FAIL %s_score: got %0d expected %0d", tag, score, e);
        end
        n_tests++;
        if (perfect !== (e == 256)) begin
            n_fail++;
            $display("FAIL %s_perfect: got %b expected %b", tag, perfect, (e == 256));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%b busy=%b expected 0/0", tag, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        n_tests++;
        if ({in_ready, out_valid, perfect, busy} !== 4'b0 || score !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b ov=%b perf=%b busy=%b score=%0d expected all 0",
                     in_ready, out_valid, perfect, busy, score);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b in_ready=%b expected 0/0", busy, in_ready);
        end
    endtask

    task automatic test_correct();
        pulse_start();
        drive_eval(1'b1, -1, 1'b0, 4);
        check_latency(1'b0);
        collect("correct");
    endtask

    task automatic test_all_zero();
        pulse_start();
        drive_eval(1'b0, -1, 1'b0, 4);
        check_latency(1'b0);
        collect("all_zero");
    endtask

    task automatic test_backpressure();
        int e;
        pulse_start();
        drive_eval(1'b1, -1, 1'b0, 4);
        check_latency(1'b0);
        e = (exp_q.size() > 0) ? exp_q[0] : -1;
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || score !== 9'(e)) begin
                n_fail++;
                $display("FAIL backpressure_c%0d: ov=%b rdy=%b score=%0d expected 1/0/%0d",
                         c, out_valid, in_ready, score, e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_ready: busy=%b rdy=%b ov=%b expected 0/0/0", busy, in_ready, out_valid);
        end
    endtask

    task automatic test_bubbles();
        pulse_start();
        drive_eval(1'b1, -1, 1'b1, 4);
        check_latency(1'b1);
        collect("bubbles");
    endtask

    task automatic test_mid_reset();
        bit seen = 1'b0;
        pulse_start();
        drive_eval(1'b1, -1, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, perfect, busy} !== 4'b0 || score !== 9'd0) begin
            n_fail++;
            $display("FAIL mid_reset_values: rdy=%b ov=%b perf=%b busy=%b score=%0d expected all 0",
                     in_ready, out_valid, perfect, busy, score);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_reset_no_output: out_valid seen=1 expected 0");
        end
        pulse_start();
        drive_eval(1'b0, -1, 1'b0, 4);
        check_latency(1'b0);
        collect("after_reset");
    endtask

    task automatic test_single_wrong();
        pulse_start();
        drive_eval(1'b1, 1, 1'b0, 4);
        check_latency(1'b0);
        collect("single_wrong");
    endtask

    initial begin
        test_reset();
        test_correct();
        test_all_zero();
        test_backpressure();
        test_bubbles();
        test_mid_reset();
        test_single_wrong();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
